// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Passive monitor for an 8-digit, common-anode, multiplexed 7-segment bus.
// It samples the seg/sel pins, waits for each digit to settle, and
// inverse-decodes the pattern to a hex nibble plus a decimal-point bit.
// Once all eight digits are captured, it publishes the 32-bit value.
//
// Output handshake: frame_valid is a single-cycle strobe with no ready.
// data_out and dot_out change only on that strobe and hold until the next
// one. code_err and sel_err are also independent single-cycle strobes.
module seg7_scan_decoder #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int SETTLE_CYC = 4,
  parameter int TIMEOUT_MS = 20
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  seg_in,
  input  logic [7:0]  sel_in,
  output logic [31:0] data_out,
  output logic [7:0]  dot_out,
  output logic        frame_valid,
  output logic        stale,
  output logic        code_err,
  output logic        sel_err
);

  localparam int TO_CYC = CLK_FREQ / 1000 * TIMEOUT_MS;
  localparam int TO_W   = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TO_CYC - 1);
  localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);
  // The counter saturates at SETTLE_CYC-1.
  // The settled event fires on the cycle the counter steps into that value.
  localparam logic [7:0] SETTLE_MAX = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] SETTLE_PRE = 8'(SETTLE_CYC - 2);

  logic [7:0]      seg_s1, sel_s1, seg_s2, sel_s2, seg_prev, sel_prev;
  logic [7:0]      settle_cnt;
  logic            armed;
  logic            changed, settled;
  logic [7:0]      sel_low;
  logic            sel_none, sel_one, sel_multi;
  logic [2:0]      sel_idx;
  logic [3:0]      glyph_nib;
  logic            glyph_ok;
  logic            cap_legal, cap_bad_glyph, cap_bad_sel;
  logic [31:0]     shadow;
  logic [7:0]      dshadow, seen;
  logic            frame_done;
  logic [TO_W-1:0] to_cnt;

  // Two-flop input synchronizer plus a copy of the previous s2 sample.
  // The synchronizer resets to the idle (blank) bus level.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      seg_s1   <= 8'hFF;
      sel_s1   <= 8'hFF;
      seg_s2   <= 8'hFF;
      sel_s2   <= 8'hFF;
      seg_prev <= 8'hFF;
      sel_prev <= 8'hFF;
    end else begin
      seg_s1   <= seg_in;
      sel_s1   <= sel_in;
      seg_s2   <= seg_s1;
      sel_s2   <= sel_s1;
      seg_prev <= seg_s2;
      sel_prev <= sel_s2;
    end
  end

  // Change detection and the settled event for the current dwell.
  always_comb begin
    changed = ({seg_s2, sel_s2} != {seg_prev, sel_prev});
    settled = armed && !changed && (settle_cnt == SETTLE_PRE);
  end

  // Settle counter: restarts on any change, saturates once settled.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      settle_cnt <= 8'd0;
    end else if (changed) begin
      settle_cnt <= 8'd0;
    end else if (settle_cnt != SETTLE_MAX) begin
      settle_cnt <= settle_cnt + 8'd1;
    end
  end

  // Armed flag: one capture per dwell, re-armed by any pattern change.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      armed <= 1'b1;
    end else if (changed) begin
      armed <= 1'b1;
    end else if (settled) begin
      armed <= 1'b0;
    end
  end

  // Digit-select classification: blank, exactly one digit, or several.
  always_comb begin
    sel_low   = ~sel_s2;
    sel_none  = (sel_low == 8'd0);
    sel_multi = ((sel_low & (sel_low - 8'd1)) != 8'd0);
    sel_one   = !sel_none && !sel_multi;
    sel_idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (sel_low[i]) sel_idx = 3'(i);
    end
  end

  // Inverse glyph table (gfedcba, active-low) to a hex nibble.
  always_comb begin
    glyph_nib = 4'h0;
    glyph_ok  = 1'b1;
    case (seg_s2[6:0])
      7'h40: glyph_nib = 4'h0;
      7'h79: glyph_nib = 4'h1;
      7'h24: glyph_nib = 4'h2;
      7'h30: glyph_nib = 4'h3;
      7'h19: glyph_nib = 4'h4;
      7'h12: glyph_nib = 4'h5;
      7'h02: glyph_nib = 4'h6;
      7'h78: glyph_nib = 4'h7;
      7'h00: glyph_nib = 4'h8;
      7'h10: glyph_nib = 4'h9;
      7'h08: glyph_nib = 4'hA;
      7'h03: glyph_nib = 4'hB;
      7'h46: glyph_nib = 4'hC;
      7'h21: glyph_nib = 4'hD;
      7'h06: glyph_nib = 4'hE;
      7'h0E: glyph_nib = 4'hF;
      default: glyph_ok = 1'b0;
    endcase
  end

  // Outcome of a settled pattern; a blanked bus produces none of these.
  always_comb begin
    cap_legal     = settled && sel_one && glyph_ok;
    cap_bad_glyph = settled && sel_one && !glyph_ok;
    cap_bad_sel   = settled && sel_multi;
    frame_done    = (seen == 8'hFF);
  end

  // Per-digit shadow registers for nibble and decimal point.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      shadow  <= 32'd0;
      dshadow <= 8'd0;
    end else if (cap_legal) begin
      shadow[{sel_idx, 2'b00} +: 4] <= glyph_nib;
      dshadow[sel_idx]              <= ~seg_s2[7];
    end
  end

  // Seen mask: cleared as the frame is published, set by each legal capture.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      seen <= 8'd0;
    end else begin
      seen <= (frame_done ? 8'd0 : seen) | (cap_legal ? (8'd1 << sel_idx) : 8'd0);
    end
  end

  // Published frame plus the error strobes, registered one cycle after the event.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      data_out    <= 32'd0;
      dot_out     <= 8'd0;
      frame_valid <= 1'b0;
      code_err    <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      frame_valid <= frame_done;
      code_err    <= cap_bad_glyph;
      sel_err     <= cap_bad_sel;
      if (frame_done) begin
        data_out <= shadow;
        dot_out  <= dshadow;
      end
    end
  end

  // Frame timeout: a completed frame restarts it; staying at the limit marks the bus stale.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      to_cnt <= '0;
      stale  <= 1'b1;
    end else if (frame_done) begin
      to_cnt <= '0;
      stale  <= 1'b0;
    end else begin
      if (to_cnt != TO_LIMIT) to_cnt <= to_cnt + TO_ONE;
      if (to_cnt == TO_LIMIT) stale  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Testbench for seg7_scan_decoder: directed scan-bus stimulus with a frame
// scoreboard; the timeout is shortened to 20 cycles (1 kHz clock, 20 ms).
module tb_seg7_scan_decoder;

  logic        sys_clk;
  logic        sys_rst;
  logic [7:0]  seg_in;
  logic [7:0]  sel_in;
  logic [31:0] data_out;
  logic [7:0]  dot_out;
  logic        frame_valid;
  logic        stale;
  logic        code_err;
  logic        sel_err;

  logic [39:0] exp_q[$];

  int   n_checks   = 0;
  int   n_fail     = 0;
  int   n_frames   = 0;
  int   n_code_err = 0;
  int   n_sel_err  = 0;
  int   cyc        = 0;
  int   fv_cyc     = 0;
  int   rise_cyc   = 0;
  logic rise_seen  = 1'b0;
  logic prev_stale = 1'b0;

  seg7_scan_decoder #(
    .CLK_FREQ  (1000),
    .SETTLE_CYC(4),
    .TIMEOUT_MS(20)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .seg_in     (seg_in),
    .sel_in     (sel_in),
    .data_out   (data_out),
    .dot_out    (dot_out),
    .frame_valid(frame_valid),
    .stale      (stale),
    .code_err   (code_err),
    .sel_err    (sel_err)
  );

  // ---------------- clock / reset block ----------------
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    repeat (20000) @(posedge sys_clk);
    $display("FAIL watchdog: got no end of test after 20000 cycles, required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_digit(input int k, input logic [6:0] seg7, input logic dp, input int n);
    logic [7:0] m;
    m      = 8'd1 << k;
    sel_in = ~m;
    seg_in = {~dp, seg7};
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic blank(input int n);
    sel_in = 8'hFF;
    seg_in = 8'hFF;
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Drive every digit whose bit is set in mask, 10 cycles each, digit 0 first.
  task automatic send_digits(input logic [31:0] vals, input logic [7:0] dots, input logic [7:0] mask);
    for (int k = 0; k < 8; k++) begin
      if (mask[k]) drive_digit(k, glyph(vals[4*k +: 4]), dots[k], 10);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (frame_valid) begin
        logic [39:0] e;
        n_frames++;
        fv_cyc    = cyc;
        rise_seen = 1'b0;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame: got frame_valid with data_out=%0h, required no frame", data_out);
        end else begin
          e = exp_q.pop_front();
          check("frame_data", data_out, e[39:8]);
          check("frame_dot", dot_out, e[7:0]);
          check("frame_stale_clear", stale, 0);
        end
      end
      if (code_err) n_code_err++;
      if (sel_err)  n_sel_err++;
      if (stale && !prev_stale && !rise_seen) begin
        rise_seen = 1'b1;
        rise_cyc  = cyc;
      end
      prev_stale = stale;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int w;
    sys_rst = 1'b1;
    seg_in  = 8'hFF;
    sel_in  = 8'hFF;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_data_out", data_out, 0);
    check("rst_dot_out", dot_out, 0);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_code_err", code_err, 0);
    check("rst_sel_err", sel_err, 0);
    check("rst_stale", stale, 1);
    sys_rst = 1'b0;
    blank(5);

    // Full frame 8,7,...,1 with dp on digit 3.
    exp_q.push_back({32'h87654321, 8'h08});
    send_digits(32'h87654321, 8'h08, 8'hFF);
    blank(3);
    check("frame1_count", n_frames, 1);
    check("frame1_stale", stale, 0);

    // Timeout: bus idle after a frame, stale rises 20 cycles after frame_valid.
    w = 0;
    while (!rise_seen && w < 60) begin
      @(posedge sys_clk);
      #1;
      w++;
    end
    check("timeout_seen", rise_seen, 1);
    check("timeout_delay", rise_cyc - fv_cyc, 20);
    check("timeout_stale", stale, 1);

    // The next full frame clears stale.
    exp_q.push_back({32'h9FEDCBA0, 8'hA5});
    send_digits(32'h9FEDCBA0, 8'hA5, 8'hFF);
    blank(3);
    check("frame2_count", n_frames, 2);
    check("frame2_stale", stale, 0);

    // Glitch rejection: an illegal pattern held SETTLE_CYC-1 cycles is never seen.
    drive_digit(4, 7'h7F, 1'b0, 3);
    blank(10);
    check("glitch_short_code_err", n_code_err, 0);
    // Digit 2: brief '8' then a settled '2'.
    drive_digit(2, 7'h00, 1'b0, 2);
    drive_digit(2, 7'h24, 1'b0, 20);
    exp_q.push_back({32'hC0FFE2E1, 8'h00});
    send_digits(32'hC0FFE2E1, 8'h00, 8'hFB);
    blank(3);
    check("glitch_frame_count", n_frames, 3);
    check("glitch_code_err", n_code_err, 0);

    // Illegal glyph on digit 5: one code_err, no frame until digit 5 is resent.
    drive_digit(5, 7'h7F, 1'b0, 10);
    check("bad_glyph_code_err", n_code_err, 1);
    send_digits(32'h13579BDF, 8'h20, 8'hDF);
    blank(10);
    check("bad_glyph_no_frame", n_frames, 3);
    exp_q.push_back({32'h13579BDF, 8'h20});
    drive_digit(5, glyph(4'h5), 1'b1, 10);
    blank(3);
    check("bad_glyph_resend_frame", n_frames, 4);

    // Two digits selected at once: one sel_err, nothing captured.
    sel_in = 8'hFC;
    seg_in = {1'b1, glyph(4'h1)};
    repeat (10) @(posedge sys_clk);
    #1;
    blank(3);
    check("sel_err_count", n_sel_err, 1);
    check("sel_err_no_frame", n_frames, 4);

    // Reset mid-frame discards the partial capture.
    send_digits(32'h44332211, 8'h00, 8'h1F);
    blank(3);
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    check("midrst_data_out", data_out, 0);
    check("midrst_dot_out", dot_out, 0);
    check("midrst_stale", stale, 1);
    send_digits(32'h44332211, 8'h00, 8'hE0);
    blank(15);
    check("midrst_no_frame", n_frames, 4);

    check("final_exp_q_empty", exp_q.size(), 0);
    check("final_code_err_total", n_code_err, 1);
    check("final_sel_err_total", n_sel_err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
